// File: rtl/mux_nto1_pipe.sv
// ============================================================================
// Module  : mux_nto1_pipe
// Brief   : Registered N-to-1 datapath mux with valid/ready handshake and a
//           round-robin scan mode. Optional macro MUX_RANGE_CHECK_EN adds
//           sel_err and drops out-of-range direct-mode offers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
`ifdef MUX_RANGE_CHECK_EN
  output logic                    sel_err,
`endif
  input  logic                    out_ready
);

  localparam logic [SEL_W:0]   C_N_IN_W  = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(N_IN - 1);

  generate
    if ((2**SEL_W) < N_IN || N_IN < 2 || N_IN > 16) begin : g_bad_params
      $error("mux_nto1_pipe: N_IN must be 2..16 and fit in SEL_W bits");
    end
  endgenerate

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] scan_ptr_q,  scan_ptr_d;
  logic             mode_q,      mode_d;
  logic             sel_err_q,   sel_err_d;

  logic             w_accept;
  logic             w_load;
  logic             w_scan_start;
  logic             w_sel_oob;
  logic [SEL_W-1:0] w_ch;
  logic [WIDTH-1:0] w_ch_data;

  assign in_ready     = !out_valid_q || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_scan_start = mode && !mode_q;
  assign w_sel_oob    = !mode && ({1'b0, sel} >= C_N_IN_W);
  assign w_ch         = mode ? (w_scan_start ? '0 : scan_ptr_q) : sel;

`ifdef MUX_RANGE_CHECK_EN
  // Out-of-range offers are consumed upstream but never reach the output.
  assign w_load  = w_accept && !w_sel_oob;
  assign sel_err = sel_err_q;
`else
  assign w_load  = w_accept;
`endif

  // Channels beyond N_IN have no source and read as zero.
  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (w_ch == SEL_W'(k)) begin
        w_ch_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    scan_ptr_d  = scan_ptr_q;
    mode_d      = mode;
    sel_err_d   = w_accept && w_sel_oob;

    if (w_load) begin
      out_data_d  = w_ch_data;
      out_chan_d  = w_ch;
      out_valid_d = 1'b1;
    end else if (!w_accept && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (mode) begin
      if (w_accept) begin
        scan_ptr_d = (w_ch == C_LAST_CH) ? '0 : w_ch + SEL_W'(1);
      end else if (w_scan_start) begin
        scan_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      scan_ptr_q  <= '0;
      mode_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      scan_ptr_q  <= scan_ptr_d;
      mode_q      <= mode_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifndef MUX_RANGE_CHECK_EN
  logic w_unused;
  assign w_unused = sel_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_pipe.sv
// ============================================================================
// Module  : tb_mux_nto1_pipe
// Brief   : Drives a 4-input and a 3-input mux_nto1_pipe with directed and
//           random traffic, comparing both against a cycle-level reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_pipe;

  typedef struct packed {
    bit       v;
    bit [7:0] data;
    bit [1:0] chan;
    bit [1:0] ptr;
    bit       pm;
    bit       err;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data4;
  logic [23:0] in_data3;
  logic [1:0]  sel;
  logic        mode, in_valid, out_ready;

  logic        rdy4, vld4, rdy3, vld3;
  logic [7:0]  dat4, dat3;
  logic [1:0]  chn4, chn3;
`ifdef MUX_RANGE_CHECK_EN
  logic        err4, err3;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  model_t m4, m3;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(8), .N_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy4), .out_data(dat4), .out_chan(chn4),
    .out_valid(vld4),
`ifdef MUX_RANGE_CHECK_EN
    .sel_err(err4),
`endif
    .out_ready(out_ready)
  );

  mux_nto1_pipe #(.WIDTH(8), .N_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy3), .out_data(dat3), .out_chan(chn3),
    .out_valid(vld3),
`ifdef MUX_RANGE_CHECK_EN
    .sel_err(err3),
`endif
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock edge of the mux, from the behavioural rules.
  function automatic model_t step(model_t m, int n, logic [31:0] din, bit rst,
                                  bit iv, bit md, bit [1:0] s, bit ordy);
    model_t r;
    bit     acc;
    int     ch;
    r = m;
    if (!rst) return '0;
    acc   = iv && (!m.v || ordy);
    ch    = md ? (m.pm ? int'(m.ptr) : 0) : int'(s);
    r.err = 1'b0;
    if (acc) begin
`ifdef MUX_RANGE_CHECK_EN
      if (!md && ch >= n) r.err = 1'b1;
      else
`endif
      begin
        r.v    = 1'b1;
        r.chan = 2'(ch);
        r.data = (ch < n) ? din[ch*8 +: 8] : 8'd0;
      end
    end else if (ordy) begin
      r.v = 1'b0;
    end
    if (md && acc)        r.ptr = 2'((ch + 1) % n);
    else if (md && !m.pm) r.ptr = 2'd0;
    r.pm = md;
    return r;
  endfunction

  task automatic cycle(input bit r, input bit iv, input bit md,
                       input bit [1:0] s, input bit ordy);
    @(negedge clk);
    rst_n = r; in_valid = iv; mode = md; sel = s; out_ready = ordy;
    #1;
    chk("in_ready4", 32'(rdy4), 32'(!m4.v || ordy));
    chk("in_ready3", 32'(rdy3), 32'(!m3.v || ordy));
    m4 = step(m4, 4, in_data4, r, iv, md, s, ordy);
    m3 = step(m3, 3, {8'd0, in_data3}, r, iv, md, s, ordy);
    @(posedge clk);
    #1;
    chk("out_valid4", 32'(vld4), 32'(m4.v));
    chk("out_data4",  32'(dat4), 32'(m4.data));
    chk("out_chan4",  32'(chn4), 32'(m4.chan));
    chk("out_valid3", 32'(vld3), 32'(m3.v));
    chk("out_data3",  32'(dat3), 32'(m3.data));
    chk("out_chan3",  32'(chn3), 32'(m3.chan));
`ifdef MUX_RANGE_CHECK_EN
    chk("sel_err4", 32'(err4), 32'(m4.err));
    chk("sel_err3", 32'(err3), 32'(m3.err));
`endif
  endtask

  initial begin
    bit md;
    m4 = '0; m3 = '0;
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
    in_data4 = {8'd0, 8'd3, 8'd2, 8'd1};
    in_data3 = {8'd3, 8'd2, 8'd1};

    // Reset held for two edges
    cycle(0, 1, 0, 2'd1, 0);
    cycle(0, 1, 0, 2'd1, 0);
    chk("rst_data_literal", 32'(dat4), 32'd0);

    // Reset release then single sel=2 accept
    cycle(1, 1, 0, 2'd2, 1);
    chk("lat_data_literal", 32'(dat4), 32'd3);
    cycle(1, 0, 0, 2'd0, 1);

    // Direct select sweep, three cycles each, including sel=3 (out of range for N_IN=3)
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 2'(s), 1);

    // Backpressure: stall three cycles while offering sel=2, then release
    cycle(1, 1, 0, 2'd1, 1);
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 2'd2, 0);
    chk("stall_data_literal", 32'(dat4), 32'd2);
    cycle(1, 1, 0, 2'd2, 1);
    chk("release_data_literal", 32'(dat4), 32'd3);

    // Scan: mode 0->1, pause mid-sequence, continue past the wrap
    cycle(1, 0, 0, 2'd0, 1);
    for (int k = 0; k < 3; k++) cycle(1, 1, 1, 2'd3, 1);
    cycle(1, 0, 1, 2'd3, 1);
    cycle(1, 0, 1, 2'd3, 1);
    for (int k = 0; k < 5; k++) cycle(1, 1, 1, 2'd3, 1);

    // Scan restart without accept on the first mode=1 cycle
    cycle(1, 1, 0, 2'd1, 1);
    cycle(1, 0, 1, 2'd0, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 1, 2'd0, 1);

    // Mid-transfer reset discards a stalled beat
    cycle(1, 1, 0, 2'd2, 0);
    cycle(1, 1, 0, 2'd1, 0);
    cycle(0, 1, 1, 2'd1, 0);

    // Random traffic
    md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      in_data4 = $urandom;
      in_data3 = 24'($urandom);
      if ($urandom_range(0, 7) == 0) md = ~md;
      cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, md,
            2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
Parametrised, registered N-to-1 datapath multiplexer with a valid/ready handshake. It supersedes the fixed 8-bit 4-to-1 combinational mux in the CPU datapath wherever the selected operand must be pipelined. Besides direct select, a scan mode steps round-robin through the inputs on each accepted transfer. It sits between operand sources (register file, immediate, ALU result, memory data) and a downstream pipeline stage.

Parameters:
WIDTH, 8, data width of each input channel and of out_data
N_IN, 4, number of input channels; legal range 2..16
SEL_W, 2, select/channel-index width; 2**SEL_W >= N_IN is required and elaboration fails otherwise

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
in_data  in  N_IN*WIDTH  flat input bus; channel k at bits [k*WIDTH +: WIDTH]
sel  in  SEL_W  channel select, used in direct mode only
mode  in  1  0 = direct (use sel), 1 = scan (use internal pointer)
in_valid  in  1  upstream offers a transfer this cycle
in_ready  out  1  block can accept a transfer this cycle
out_data  out  WIDTH  registered selected data
out_chan  out  SEL_W  index of the channel that produced out_data
out_valid  out  1  out_data/out_chan hold a valid beat
out_ready  in  1  downstream accepts the beat this cycle

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_chan=0, scan_ptr=0, mode_q=0. Reset asserted mid-transfer discards the held beat; no partial state survives.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept = in_valid && in_ready. On accept, the next edge loads out_data = channel[ch], out_chan = ch, out_valid = 1. Latency is 1 cycle, accept to out_valid.
- ch = sel when mode=0. ch = scan_ptr when mode=1.
- Output drain: out_valid && out_ready && !accept → out_valid=0 next edge. out_data and out_chan hold their last values.
- Simultaneous drain and accept: the new beat replaces the old one and out_valid stays 1. Full throughput is 1 beat/cycle.
- Stall: out_valid && !out_ready → out_data, out_chan and out_valid are held stable and in_ready=0.
- scan_ptr (SEL_W bits) increments on each accept while mode=1. It wraps N_IN-1 → 0, including when N_IN is not a power of 2.
- scan_ptr holds its value in mode=0.
- mode_q registers mode each cycle. A 0→1 transition (mode=1 && mode_q=0) forces ch = 0 for that cycle, and scan_ptr then becomes 1 if the cycle accepts, or 0 if it does not.
- Out-of-range select (mode=0, sel >= N_IN): by default the transfer is accepted with out_data = 0 and out_chan = sel. The optional feature changes this.
- Data is passed unmodified: no sign or width conversion.

Optional Feature:
MUX_RANGE_CHECK_EN
- Defined: adds output port sel_err (1 bit, reset 0). For a direct-mode offer with sel >= N_IN and in_ready=1:
  - the beat is consumed from upstream but not loaded, so out_valid, out_data and out_chan are unchanged;
  - sel_err pulses high for exactly the following cycle.
- Not defined: no sel_err port, and the default out-of-range behaviour applies (zero data forwarded with out_valid=1).

Test Plan:
- Channel data 1,2,3,0 (WIDTH=8, N_IN=4). Direct mode, sel=0,1,2,3 held for 30 ns each, in_valid=1, out_ready=1 → each cycle out_data is the previous cycle's channel value (1,2,3,0) and out_chan matches sel.
- Reset/latency: hold rst_n=0 for 2 edges → out_valid=0, out_data=0 and in_ready=1. Release rst_n, then accept sel=2 → out_data=3 and out_valid=1 exactly one edge later.
- Backpressure: accept sel=1, then hold out_ready=0 for 3 cycles while offering sel=2 → out_data stays 2, in_ready=0. Raise out_ready → the sel=2 beat is accepted and out_data=3 on the next edge.
- Scan: mode 0→1, in_valid=1, out_ready=1 for 6 cycles → out_chan sequence 0,1,2,3,0,1 and out_data 1,2,3,0,1,2. Drop in_valid for 2 cycles mid-sequence → the pointer does not advance.
- Non-power-of-2 wrap (N_IN=3, SEL_W=2): scan for 5 accepts → out_chan sequence 0,1,2,0,1.
- Out-of-range (N_IN=3, sel=3): without MUX_RANGE_CHECK_EN → out_valid=1, out_data=0, out_chan=3. With MUX_RANGE_CHECK_EN → out_valid unchanged and sel_err=1 for one cycle.
